// File: rtl/alu_muldiv_iter.sv
// Integer execute unit: single-cycle RV32I/RV64I ALU ops plus iterative M-extension
// multiply (shift-add) and divide (restoring), with valid/ready handshake and flush.
module alu_muldiv_iter #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] ReadData1,
    input  logic [XLEN-1:0] ReadData2,
    input  logic [XLEN-1:0] imm,
    input  logic            ALUSrc,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic            is_imm_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ALUResult,
    output logic            zero
);

    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned DW  = 2 * XLEN;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [SHW-1:0]  LAST_STEP = SHW'(XLEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [SHW-1:0]  r_cnt, w_cnt_nxt;
    logic [XLEN-1:0] r_hi, w_hi_nxt;
    logic [XLEN-1:0] r_lo, w_lo_nxt;
    logic [XLEN-1:0] r_opnd, w_opnd_nxt;
    logic            r_neg_a, w_neg_a_nxt;
    logic            r_neg_b, w_neg_b_nxt;
    logic            r_sel, w_sel_nxt;
    logic [XLEN-1:0] r_result, w_result_nxt;
    logic            r_zero, w_zero_nxt;
    logic            r_out_valid, w_out_valid_nxt;

    logic [XLEN-1:0] w_op2;
    logic [SHW-1:0]  w_shamt;
    logic            w_accept;
    logic            w_f7_plain;
    logic            w_is_m;
    logic [XLEN-1:0] w_base_res;

    logic            w_a_sgn, w_b_sgn;
    logic [XLEN-1:0] w_a_mag, w_b_mag;
    logic            w_div_zero, w_div_ovf;

    logic [XLEN:0]   w_mul_sum;
    logic [XLEN-1:0] w_mul_hi, w_mul_lo;
    logic [DW-1:0]   w_prod, w_prod_fix;
    logic [XLEN-1:0] w_mul_res;

    logic [XLEN:0]   w_div_shift;
    logic            w_div_ge;
    logic [XLEN-1:0] w_div_hi, w_div_lo;
    logic [XLEN-1:0] w_quo_fix, w_rem_fix, w_div_res;

    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = r_out_valid;
    assign ALUResult  = r_result;
    assign zero       = r_zero;

    assign w_op2      = ALUSrc ? imm : ReadData2;
    assign w_shamt    = w_op2[SHW-1:0];
    assign w_accept   = in_valid & in_ready & ~flush;
    assign w_f7_plain = is_imm_op | (funct7 == 7'b0000000);
    assign w_is_m     = ~is_imm_op & (funct7 == 7'b0000001);

    // Operand signedness: div ops signed when funct3[0]=0; MULHSU treats rs2 unsigned, MULHU both.
    assign w_a_sgn = ReadData1[XLEN-1] & (funct3[2] ? ~funct3[0] : (funct3 != 3'b011));
    assign w_b_sgn = w_op2[XLEN-1]     & (funct3[2] ? ~funct3[0] : ~funct3[1]);
    assign w_a_mag = w_a_sgn ? (-ReadData1) : ReadData1;
    assign w_b_mag = w_b_sgn ? (-w_op2) : w_op2;
    assign w_div_zero = (w_op2 == '0);
    assign w_div_ovf  = ~funct3[0] & (ReadData1 == MOST_NEG) & (w_op2 == '1);

    // Shift-add step: hi accumulates, lo holds remaining multiplier bits then product low half.
    assign w_mul_sum  = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_opnd : {XLEN{1'b0}})};
    assign w_mul_hi   = w_mul_sum[XLEN:1];
    assign w_mul_lo   = {w_mul_sum[0], r_lo[XLEN-1:1]};
    assign w_prod     = {w_mul_hi, w_mul_lo};
    assign w_prod_fix = r_neg_a ? (-w_prod) : w_prod;
    assign w_mul_res  = r_sel ? w_prod_fix[DW-1:XLEN] : w_prod_fix[XLEN-1:0];

    // Restoring step: hi is partial remainder, lo shifts dividend out and quotient in.
    assign w_div_shift = {r_hi, r_lo[XLEN-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
    assign w_div_hi    = w_div_ge ? (w_div_shift[XLEN-1:0] - r_opnd) : w_div_shift[XLEN-1:0];
    assign w_div_lo    = {r_lo[XLEN-2:0], w_div_ge};
    assign w_quo_fix   = r_neg_a ? (-w_div_lo) : w_div_lo;
    assign w_rem_fix   = r_neg_b ? (-w_div_hi) : w_div_hi;
    assign w_div_res   = r_sel ? w_rem_fix : w_quo_fix;

    always_comb begin
        w_base_res = '0;
        case (funct3)
            3'b000: begin
                if (w_f7_plain)                    w_base_res = ReadData1 + w_op2;
                else if (funct7 == 7'b0100000)     w_base_res = ReadData1 - w_op2;
            end
            3'b001: if (w_f7_plain) w_base_res = ReadData1 << w_shamt;
            3'b010: if (w_f7_plain)
                w_base_res = {{(XLEN-1){1'b0}}, ($signed(ReadData1) < $signed(w_op2))};
            3'b011: if (w_f7_plain)
                w_base_res = {{(XLEN-1){1'b0}}, (ReadData1 < w_op2)};
            3'b100: if (w_f7_plain) w_base_res = ReadData1 ^ w_op2;
            3'b101: begin
                if (is_imm_op ? funct7[5] : (funct7 == 7'b0100000))
                    w_base_res = $unsigned($signed(ReadData1) >>> w_shamt);
                else if (w_f7_plain)
                    w_base_res = ReadData1 >> w_shamt;
            end
            3'b110: if (w_f7_plain) w_base_res = ReadData1 | w_op2;
            3'b111: if (w_f7_plain) w_base_res = ReadData1 & w_op2;
            default: w_base_res = '0;
        endcase
    end

    // Next-state and datapath control.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_hi_nxt     = r_hi;
        w_lo_nxt     = r_lo;
        w_opnd_nxt   = r_opnd;
        w_neg_a_nxt  = r_neg_a;
        w_neg_b_nxt  = r_neg_b;
        w_sel_nxt    = r_sel;
        w_result_nxt = r_result;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_cnt_nxt = '0;
                    if (!w_is_m) begin
                        w_result_nxt = w_base_res;
                        w_state_nxt  = S_DONE;
                    end else if (!funct3[2]) begin
                        w_hi_nxt    = '0;
                        w_lo_nxt    = w_b_mag;
                        w_opnd_nxt  = w_a_mag;
                        w_neg_a_nxt = w_a_sgn ^ w_b_sgn;
                        w_sel_nxt   = (funct3 != 3'b000);
                        w_state_nxt = S_MUL;
                    end else if (w_div_zero) begin
                        w_result_nxt = funct3[1] ? ReadData1 : '1;
                        w_state_nxt  = S_DONE;
                    end else if (w_div_ovf) begin
                        w_result_nxt = funct3[1] ? '0 : MOST_NEG;
                        w_state_nxt  = S_DONE;
                    end else begin
                        w_hi_nxt    = '0;
                        w_lo_nxt    = w_a_mag;
                        w_opnd_nxt  = w_b_mag;
                        w_neg_a_nxt = w_a_sgn ^ w_b_sgn;
                        w_neg_b_nxt = w_a_sgn;
                        w_sel_nxt   = funct3[1];
                        w_state_nxt = S_DIV;
                    end
                end
            end
            S_MUL: begin
                w_cnt_nxt = r_cnt + SHW'(1);
                w_hi_nxt  = w_mul_hi;
                w_lo_nxt  = w_mul_lo;
                if (r_cnt == LAST_STEP) begin
                    w_result_nxt = w_mul_res;
                    w_state_nxt  = S_DONE;
                end
            end
            S_DIV: begin
                w_cnt_nxt = r_cnt + SHW'(1);
                w_hi_nxt  = w_div_hi;
                w_lo_nxt  = w_div_lo;
                if (r_cnt == LAST_STEP) begin
                    w_result_nxt = w_div_res;
                    w_state_nxt  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (flush) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end

        w_zero_nxt      = (w_result_nxt == '0);
        w_out_valid_nxt = (w_state_nxt == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_opnd      <= '0;
            r_neg_a     <= 1'b0;
            r_neg_b     <= 1'b0;
            r_sel       <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_hi        <= w_hi_nxt;
            r_lo        <= w_lo_nxt;
            r_opnd      <= w_opnd_nxt;
            r_neg_a     <= w_neg_a_nxt;
            r_neg_b     <= w_neg_b_nxt;
            r_sel       <= w_sel_nxt;
            r_result    <= w_result_nxt;
            r_zero      <= w_zero_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

endmodule

// File: tb/tb_alu_muldiv_iter.sv
// Self-checking bench for alu_muldiv_iter (XLEN=32): directed vectors, random ops against an
// arithmetic reference model, DONE stall, flush and mid-operation reset.
module tb_alu_muldiv_iter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] ReadData1 = '0;
    logic [31:0] ReadData2 = '0;
    logic [31:0] imm = '0;
    logic        ALUSrc = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic        is_imm_op = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] ALUResult;
    logic        zero;

    int checks = 0;
    int errors = 0;

    alu_muldiv_iter #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .imm(imm),
        .ALUSrc(ALUSrc), .funct3(funct3), .funct7(funct7), .is_imm_op(is_imm_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALUResult(ALUResult), .zero(zero)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Reference result from RISC-V arithmetic rules; b is the already-selected second operand.
    function automatic logic [31:0] model_res(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] f3, input logic [6:0] f7,
                                              input logic isim);
        int          sa, sb;
        longint      p;
        logic [63:0] up;
        logic [4:0]  sh;
        logic        plain;
        sa = a;
        sb = b;
        sh = b[4:0];
        plain = isim || (f7 == 7'h00);
        if (!isim && f7 == 7'h01) begin
            case (f3)
                3'd0: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
                3'd1: begin p = longint'(sa) * longint'(sb); up = p; return up[63:32]; end
                3'd2: begin p = longint'(sa) * longint'({32'b0, b}); up = p; return up[63:32]; end
                3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
                3'd4: begin
                    if (b == 0) return 32'hFFFFFFFF;
                    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                    return 32'(sa / sb);
                end
                3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
                3'd6: begin
                    if (b == 0) return a;
                    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                    return 32'(sa % sb);
                end
                default: return (b == 0) ? a : a % b;
            endcase
        end
        case (f3)
            3'd0: begin
                if (plain) return a + b;
                if (f7 == 7'h20) return a - b;
                return 32'h0;
            end
            3'd1: return plain ? (a << sh) : 32'h0;
            3'd2: return (plain && sa < sb) ? 32'h1 : 32'h0;
            3'd3: return (plain && a < b) ? 32'h1 : 32'h0;
            3'd4: return plain ? (a ^ b) : 32'h0;
            3'd5: begin
                if (isim ? f7[5] : (f7 == 7'h20)) return 32'(sa >>> sh);
                if (plain) return a >> sh;
                return 32'h0;
            end
            3'd6: return plain ? (a | b) : 32'h0;
            default: return plain ? (a & b) : 32'h0;
        endcase
    endfunction

    function automatic int model_lat(input logic [31:0] a, input logic [31:0] b,
                                     input logic [2:0] f3, input logic [6:0] f7, input logic isim);
        if (isim || f7 != 7'h01) return 1;
        if (f3[2]) begin
            if (b == 0) return 1;
            if (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
        end
        return 33;
    endfunction

    // Issues one op from IDLE with out_ready high; returns result and accept->out_valid latency.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                          input logic src, input logic [2:0] f3, input logic [6:0] f7,
                          input logic isim, output logic [31:0] res, output logic z,
                          output int lat);
        @(negedge clk);
        ReadData1 = a; ReadData2 = b; imm = im; ALUSrc = src;
        funct3 = f3; funct7 = f7; is_imm_op = isim;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        ReadData1 = $urandom; ReadData2 = $urandom; imm = $urandom;
        funct3 = 3'($urandom); funct7 = 7'($urandom);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = ALUResult;
        z = zero;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (ALUResult !== 32'h0) begin errors++; $display("FAIL reset_result got %h want 0", ALUResult); end
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL reset_zero got %b want 0", zero); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct packed {
        logic [31:0] a, b, im;
        logic        src;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        isim;
        logic [31:0] exp;
        logic        expz;
        int          lat;
    } vec_t;

    task automatic test_directed();
        vec_t v[18];
        logic [31:0] res;
        logic z;
        int lat;
        v[0]  = '{32'd5, 32'd7, 32'd0, 1'b0, 3'd0, 7'h00, 1'b0, 32'd12, 1'b0, 1};
        v[1]  = '{32'd7, 32'd7, 32'd0, 1'b0, 3'd0, 7'h20, 1'b0, 32'd0, 1'b1, 1};
        v[2]  = '{32'd1, 32'h21, 32'd0, 1'b0, 3'd1, 7'h00, 1'b0, 32'd2, 1'b0, 1};
        v[3]  = '{32'h80000000, 32'd4, 32'd0, 1'b0, 3'd5, 7'h20, 1'b0, 32'hF8000000, 1'b0, 1};
        v[4]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, 3'd0, 7'h01, 1'b0, 32'h1, 1'b0, 33};
        v[5]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, 3'd1, 7'h01, 1'b0, 32'h0, 1'b1, 33};
        v[6]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, 3'd3, 7'h01, 1'b0, 32'hFFFFFFFE, 1'b0, 33};
        v[7]  = '{32'd7, 32'hFFFFFFFE, 32'd0, 1'b0, 3'd4, 7'h01, 1'b0, 32'hFFFFFFFD, 1'b0, 33};
        v[8]  = '{32'd7, 32'hFFFFFFFE, 32'd0, 1'b0, 3'd6, 7'h01, 1'b0, 32'd1, 1'b0, 33};
        v[9]  = '{32'd123, 32'd0, 32'd0, 1'b0, 3'd5, 7'h01, 1'b0, 32'hFFFFFFFF, 1'b0, 1};
        v[10] = '{32'd9, 32'd0, 32'd0, 1'b0, 3'd6, 7'h01, 1'b0, 32'd9, 1'b0, 1};
        v[11] = '{32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, 3'd4, 7'h01, 1'b0, 32'h80000000, 1'b0, 1};
        v[12] = '{32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, 3'd6, 7'h01, 1'b0, 32'h0, 1'b1, 1};
        v[13] = '{32'd1, 32'h55, 32'hFFFFFFFF, 1'b1, 3'd0, 7'h7F, 1'b1, 32'h0, 1'b1, 1};
        v[14] = '{32'h80000000, 32'h3, 32'h404, 1'b1, 3'd5, 7'h20, 1'b1, 32'hF8000000, 1'b0, 1};
        v[15] = '{32'd3, 32'd4, 32'd0, 1'b0, 3'd0, 7'h02, 1'b0, 32'h0, 1'b1, 1};
        v[16] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, 3'd2, 7'h01, 1'b0, 32'hFFFFFFFF, 1'b0, 33};
        v[17] = '{32'h80000000, 32'hFFFFFFFF, 32'd0, 1'b0, 3'd5, 7'h01, 1'b0, 32'h0, 1'b1, 33};
        for (int i = 0; i < 18; i++) begin
            run_op(v[i].a, v[i].b, v[i].im, v[i].src, v[i].f3, v[i].f7, v[i].isim, res, z, lat);
            checks++; if (res !== v[i].exp) begin errors++; $display("FAIL directed[%0d]_result got %h want %h", i, res, v[i].exp); end
            checks++; if (z !== v[i].expz) begin errors++; $display("FAIL directed[%0d]_zero got %b want %b", i, z, v[i].expz); end
            checks++; if (lat != v[i].lat) begin errors++; $display("FAIL directed[%0d]_latency got %0d want %0d", i, lat, v[i].lat); end
        end
    endtask

    task automatic test_random_base();
        logic [31:0] a, b, im, exp, res;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        isim, z;
        int          lat;
        for (int i = 0; i < 60; i++) begin
            a = $urandom; b = $urandom; im = $urandom;
            f3 = 3'($urandom_range(0, 7));
            isim = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                2: f7 = 7'($urandom);
                default: f7 = 7'h00;
            endcase
            if (!isim && f7 == 7'h01) f7 = 7'h00;
            exp = model_res(a, isim ? im : b, f3, f7, isim);
            run_op(a, b, im, isim, f3, f7, isim, res, z, lat);
            checks++; if (res !== exp) begin errors++; $display("FAIL base[%0d]_result f3=%0d f7=%h imm=%b got %h want %h", i, f3, f7, isim, res, exp); end
            checks++; if (z !== (exp == 32'h0)) begin errors++; $display("FAIL base[%0d]_zero got %b want %b", i, z, (exp == 32'h0)); end
            checks++; if (lat != 1) begin errors++; $display("FAIL base[%0d]_latency got %0d want 1", i, lat); end
        end
    endtask

    task automatic test_random_muldiv();
        logic [31:0] a, b, exp, res;
        logic [2:0]  f3;
        logic        z;
        int          lat, elat;
        for (int i = 0; i < 30; i++) begin
            a = $urandom; b = $urandom;
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0: b = 32'h0;
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = 32'($urandom_range(0, 100));
                default: ;
            endcase
            exp  = model_res(a, b, f3, 7'h01, 1'b0);
            elat = model_lat(a, b, f3, 7'h01, 1'b0);
            run_op(a, b, $urandom, 1'b0, f3, 7'h01, 1'b0, res, z, lat);
            checks++; if (res !== exp) begin errors++; $display("FAIL muldiv[%0d]_result f3=%0d a=%h b=%h got %h want %h", i, f3, a, b, res, exp); end
            checks++; if (z !== (exp == 32'h0)) begin errors++; $display("FAIL muldiv[%0d]_zero got %b want %b", i, z, (exp == 32'h0)); end
            checks++; if (lat != elat) begin errors++; $display("FAIL muldiv[%0d]_latency got %0d want %0d", i, lat, elat); end
        end
    endtask

    task automatic test_stall();
        logic [31:0] a, b, exp, res;
        logic        z;
        int          lat;
        a = $urandom; b = $urandom;
        exp = model_res(a, b, 3'd3, 7'h01, 1'b0);
        @(negedge clk);
        ReadData1 = a; ReadData2 = b; ALUSrc = 1'b0; funct3 = 3'd3; funct7 = 7'h01;
        is_imm_op = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin @(posedge clk); #1; lat++; end
        checks++; if (lat != 33) begin errors++; $display("FAIL stall_latency got %0d want 33", lat); end
        for (int i = 0; i < 5; i++) begin
            ReadData1 = 32'd3; ReadData2 = 32'd4; funct3 = 3'd0; funct7 = 7'h00; in_valid = 1'b1;
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall[%0d]_out_valid got %b want 1", i, out_valid); end
            checks++; if (ALUResult !== exp) begin errors++; $display("FAIL stall[%0d]_result got %h want %h", i, ALUResult, exp); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall[%0d]_in_ready got %b want 0", i, in_ready); end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_handoff_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_handoff_in_ready got %b want 1", in_ready); end
        run_op(32'd3, 32'd4, 32'd0, 1'b0, 3'd0, 7'h00, 1'b0, res, z, lat);
        checks++; if (res !== 32'd7) begin errors++; $display("FAIL stall_next_result got %h want 7", res); end
        checks++; if (lat != 1) begin errors++; $display("FAIL stall_next_latency got %0d want 1", lat); end
    endtask

    task automatic test_flush();
        logic [31:0] res;
        logic        z;
        int          lat, seen;
        @(negedge clk);
        ReadData1 = 32'd1000; ReadData2 = 32'd7; ALUSrc = 1'b0; funct3 = 3'd4; funct7 = 7'h01;
        is_imm_op = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; ReadData1 = 32'd1; ReadData2 = 32'd1; funct3 = 3'd0; funct7 = 7'h00;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_div_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_div_in_ready got %b want 1", in_ready); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (out_valid === 1'b1) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL flush_div_no_result got %0d valid cycles want 0", seen); end
        // Flush in IDLE must block a same-cycle accept.
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_idle_out_valid got %b want 0", out_valid); end
        run_op(32'd2, 32'd3, 32'd0, 1'b0, 3'd0, 7'h00, 1'b0, res, z, lat);
        checks++; if (res !== 32'd5) begin errors++; $display("FAIL flush_after_result got %h want 5", res); end
        checks++; if (lat != 1) begin errors++; $display("FAIL flush_after_latency got %0d want 1", lat); end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        ReadData1 = 32'h12345; ReadData2 = 32'h777; ALUSrc = 1'b0; funct3 = 3'd0; funct7 = 7'h01;
        is_imm_op = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %b want 0", out_valid); end
        checks++; if (ALUResult !== 32'h0) begin errors++; $display("FAIL rstmid_result got %h want 0", ALUResult); end
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL rstmid_zero got %b want 0", zero); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (out_valid === 1'b1) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL rstmid_no_result got %0d valid cycles want 0", seen); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random_base();
        test_random_muldiv();
        test_stall();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
